// File: rtl/sr_pulse_driver_if.sv
// rtl/sr_pulse_driver_if.sv - command handshake bundle between control logic and the SR pulse driver
interface sr_pulse_driver_if;
    logic cmd_valid;
    logic cmd_op;
    logic cmd_ready;
    logic cmd_done;
    logic cmd_ok;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready,
        input  cmd_done,
        input  cmd_ok
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready,
        output cmd_done,
        output cmd_ok
    );
endinterface

// File: rtl/sr_pulse_driver.sv
// rtl/sr_pulse_driver.sv - timed active-low set/reset pulse generator for a NAND SR latch with q feedback check
module sr_pulse_driver #(
    parameter int PULSE_W        = 2,
    parameter int GAP_W          = 2,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_pulse_driver_if.slave   cmd,
    output logic               sbar,
    output logic               rbar,
    input  logic               q_fb,
    output logic               q_shadow,
    output logic               err,
    input  logic               err_clr
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       op_q;
    logic       known;
    logic       q_s1;
    logic       q_s2;
    logic       ready_q;
    logic       done_q;
    logic       ok_q;

    assign cmd.cmd_ready = ready_q;
    assign cmd.cmd_done  = done_q;
    assign cmd.cmd_ok    = ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_q     <= 1'b0;
            known    <= 1'b0;
            q_shadow <= 1'b0;
            q_s1     <= 1'b0;
            q_s2     <= 1'b0;
            sbar     <= 1'b1;
            rbar     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err      <= 1'b0;
        end else begin
            q_s1   <= q_fb;
            q_s2   <= q_s1;
            done_q <= 1'b0;
            ok_q   <= 1'b0;

            // err reacts to the completion strobe itself, so a set always beats a same-cycle clear
            if (done_q && !ok_q) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        if (SKIP_REDUNDANT && known && (cmd.cmd_op == q_shadow)) begin
                            done_q <= 1'b1;
                            ok_q   <= (q_s2 == q_shadow);
                        end else begin
                            state   <= PULSE;
                            cnt     <= 4'(PULSE_W - 1);
                            op_q    <= cmd.cmd_op;
                            ready_q <= 1'b0;
                            if (cmd.cmd_op) begin
                                sbar <= 1'b0;
                            end else begin
                                rbar <= 1'b0;
                            end
                        end
                    end
                end
                PULSE: begin
                    if (cnt == 4'd0) begin
                        state <= GAP;
                        cnt   <= 4'(GAP_W - 1);
                        sbar  <= 1'b1;
                        rbar  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == 4'd0) begin
                        state    <= IDLE;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                        ok_q     <= (q_s2 == op_q);
                        q_shadow <= op_q;
                        known    <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
